// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared Mini SRC defines (memory sequencer state encodings, wait-state limit)
package mem_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int MAX_WAIT_STATES = 15;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: req/ack load/store sequencer driving ram (clk, clr, req/we/addr/wdata in; busy/ack/rdata out; ram_* to/from ram)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int depth = 9,
  parameter int width = 32,
  parameter int wait_states = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req,
  input  logic             we,
  input  logic [depth-1:0] addr,
  input  logic [width-1:0] wdata,
  output logic             busy,
  output logic             ack,
  output logic [width-1:0] rdata,
  output logic [depth-1:0] ram_r_addr,
  output logic [depth-1:0] ram_w_addr,
  output logic [width-1:0] ram_w_data,
  output logic             ram_wr_en,
  input  logic [width-1:0] ram_r_data
);
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_ACCESS = ST_ACCESS,
    S_DONE = ST_DONE
  } state_t;
  localparam logic [3:0] cnt_init = (wait_states == 0) ? 4'd0 : 4'(wait_states - 1);
  state_t state, next;
  logic [3:0] cnt;
  logic [depth-1:0] addr_q;
  logic [width-1:0] wdata_q;
  logic we_q, accept;
  always_comb begin
    accept = (state == S_IDLE) && req;
    next = (state == S_IDLE) ? (req ? ((wait_states == 0) ? S_ACCESS : S_WAIT) : S_IDLE) :
           (state == S_WAIT) ? ((cnt == 4'd0) ? S_ACCESS : S_WAIT) :
           (state == S_ACCESS) ? S_DONE : S_IDLE;
    busy = state != S_IDLE;
    ack = state == S_DONE;
    ram_wr_en = (state == S_ACCESS) && we_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr_q <= addr;
        wdata_q <= wdata;
        we_q <= we;
        cnt <= cnt_init;
      end else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == S_ACCESS && !we_q) rdata <= ram_r_data;
    end
  end
  assign ram_r_addr = addr_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with one and zero wait states against behavioural rams
module tb_mem_ctrl;
  logic clk = 1'b0, clr = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [8:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic busy0, ack0, wr0, busy1, ack1, wr1;
  logic [31:0] rdata0, rdata1, ram_w_data0, ram_w_data1, ram_r_data0, ram_r_data1;
  logic [8:0] ram_r_addr0, ram_w_addr0, ram_r_addr1, ram_w_addr1;
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] rq0[$], rq1[$];
  logic [40:0] wq0[$], wq1[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_ctrl #(.depth(9), .width(32), .wait_states(1)) dut0 (
    .clk(clk), .clr(clr), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .ram_r_addr(ram_r_addr0), .ram_w_addr(ram_w_addr0),
    .ram_w_data(ram_w_data0), .ram_wr_en(wr0), .ram_r_data(ram_r_data0));
  mem_ctrl #(.depth(9), .width(32), .wait_states(0)) dut1 (
    .clk(clk), .clr(clr), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .ack(ack1), .rdata(rdata1), .ram_r_addr(ram_r_addr1), .ram_w_addr(ram_w_addr1),
    .ram_w_data(ram_w_data1), .ram_wr_en(wr1), .ram_r_data(ram_r_data1));
  assign ram_r_data0 = mem0[ram_r_addr0];
  assign ram_r_data1 = mem1[ram_r_addr1];
  always @(posedge clk) begin
    if (wr0) mem0[ram_w_addr0] <= ram_w_data0;
    if (wr1) mem1[ram_w_addr1] <= ram_w_data1;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ack0) begin
      if (rq0.size() == 0) chk("spurious_ack0", 1, 0);
      else chk("rdata_at_ack0", rdata0, rq0.pop_front());
    end
    if (wr0) begin
      if (wq0.size() == 0) chk("spurious_write0", 1, 0);
      else chk("write0", {ram_w_addr0, ram_w_data0}, wq0.pop_front());
    end
    if (ack1) begin
      if (rq1.size() == 0) chk("spurious_ack1", 1, 0);
      else chk("rdata_at_ack1", rdata1, rq1.pop_front());
    end
    if (wr1) begin
      if (wq1.size() == 0) chk("spurious_write1", 1, 0);
      else chk("write1", {ram_w_addr1, ram_w_data1}, wq1.pop_front());
    end
  end
  task automatic set_in(input int d, input logic r, input logic w, input logic [8:0] a, input logic [31:0] wd);
    if (d == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = wd;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = wd;
    end
  endtask
  task automatic run(input int d, input logic w, input logic [8:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input int lat, input bit chg);
    int first = 0, wcnt = 0;
    @(negedge clk);
    chk("idle_before", d ? busy1 : busy0, 0);
    if (d == 0) begin
      rq0.push_back(exp_rd);
      if (w) wq0.push_back({a, wd});
    end else begin
      rq1.push_back(exp_rd);
      if (w) wq1.push_back({a, wd});
    end
    set_in(d, 1, w, a, wd);
    @(posedge clk);
    #1;
    set_in(d, 0, w, chg ? a ^ 9'h001 : a, chg ? ~wd : wd);
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      if (d ? wr1 : wr0) wcnt++;
      if ((d ? ack1 : ack0) && first == 0) first = n;
    end
    chk("ack_latency", first, lat);
    chk("wr_en_cycles", wcnt, w ? 1 : 0);
    chk("ram_addr_held", d ? ram_r_addr1 : ram_r_addr0, a);
    if (w) chk("ram_wdata_held", d ? ram_w_data1 : ram_w_data0, wd);
  endtask
  initial begin
    int first, second, acks;
    bit released;
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 0;
      mem1[i] = 0;
    end
    mem1[9'h1FF] = 32'h12345678;
    #2;
    chk("reset_busy", busy0, 0);
    chk("reset_ack", ack0, 0);
    chk("reset_rdata", rdata0, 0);
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    set_in(0, 1, 1, 9'h003, 32'h55);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_in_wait_busy", busy0, 1);
    clr = 1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_ack", ack0, 0);
    chk("abort_wr_en", wr0, 0);
    chk("abort_rdata", rdata0, 0);
    chk("abort_addr", ram_w_addr0, 0);
    chk("abort_wdata", ram_w_data0, 0);
    @(negedge clk);
    clr = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_write", mem0[3], 0);
    run(0, 1, 9'h005, 32'hDEADBEEF, 32'h0, 3, 0);
    run(0, 0, 9'h005, 32'h0, 32'hDEADBEEF, 3, 0);
    run(0, 1, 9'h020, 32'hCAFEF00D, 32'hDEADBEEF, 3, 0);
    run(0, 0, 9'h020, 32'h0, 32'hCAFEF00D, 3, 0);
    run(0, 1, 9'h021, 32'h0, 32'hCAFEF00D, 3, 0);
    chk("store_isolation", rdata0, 32'hCAFEF00D);
    @(negedge clk);
    rq0.push_back(32'hCAFEF00D);
    rq0.push_back(32'hCAFEF00D);
    wq0.push_back({9'h00A, 32'h00000A0A});
    wq0.push_back({9'h010, 32'h00001010});
    set_in(0, 1, 1, 9'h00A, 32'h0A0A);
    @(posedge clk);
    #1;
    set_in(0, 1, 1, 9'h010, 32'h1010);
    first = 0; second = 0; acks = 0; released = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
      if (n == 3) chk("held_req_mem10_untouched", mem0[9'h010], 0);
      if (!busy0 && !released) begin
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0);
        released = 1;
      end
    end
    chk("reject_first_ack", first, 3);
    chk("held_req_second_ack", second, 7);
    chk("ack_count", acks, 2);
    chk("mem_0a", mem0[9'h00A], 32'h0A0A);
    chk("mem_10", mem0[9'h010], 32'h1010);
    run(0, 1, 9'h030, 32'h3333, 32'hCAFEF00D, 3, 1);
    chk("changed_addr_not_written", mem0[9'h031], 0);
    chk("mem_30", mem0[9'h030], 32'h3333);
    run(1, 0, 9'h1FF, 32'h0, 32'h12345678, 2, 0);
    chk("zero_ws_rdata", rdata1, 32'h12345678);
    repeat (3) @(negedge clk);
    chk("rq0_drained", rq0.size(), 0);
    chk("wq0_drained", wq0.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
